fifo_rr_scheduler: RTL and testbench
====================================

// Module: fifo_rr_scheduler
// PURPOSE
//  Packet-level round-robin scheduler sharing one downstream read path among PORT_NUM input FIFOs.
//  Picks a non-empty, enabled FIFO and holds the grant until that FIFO's end-of-packet word is read.
//  Issues the per-FIFO read strobes.
//  Reports the same 8-bit selection code as the existing FIFO-select logic: 128+index when granted, 0 when idle.
// PARAMETERS
//  PORT_NUM     6    number of input FIFOs; legal range 2..127
//  CNT_W        16   width of completed-packet counter
//  TIMEOUT_CYC  255  stall cycles before grant abort; used only with FIFO_SCHED_TIMEOUT_EN; legal range 1..65535
// PORTS
//  glb_clk        in   1         single clock, all logic on rising edge
//  glb_rst        in   1         synchronous reset, active-high
//  port_en        in   PORT_NUM  per-FIFO arbitration enable
//  fifo_nempty    in   PORT_NUM  FIFO i holds at least one word
//  fifo_eop       in   PORT_NUM  head word of FIFO i is last word of its packet
//  out_ready      in   1         downstream accepts a word this cycle
//  fifo_rd        out  PORT_NUM  one-hot read strobe to granted FIFO
//  fifo_sel_code  out  8         8'd128+grant_idx while granted, 8'd0 otherwise
//  busy           out  1         grant held (state XFER)
//  pkt_cnt        out  CNT_W     completed packets, wraps modulo 2^CNT_W
//  sched_timeout  out  1         one-cycle pulse on grant abort; constant 0 without macro
// BEHAVIOUR
//  Reset, checked at posedge glb_clk while glb_rst=1:
//   - state=IDLE, grant_idx=0, busy=0, fifo_sel_code=0, pkt_cnt=0, sched_timeout=0, fifo_rd=0
//   - last_idx=PORT_NUM-1, so port 0 has first priority
//   - reset mid-packet drops the grant immediately; no completion is counted
//  Request vector: req = port_en & fifo_nempty.
//  IDLE:
//   - if req!=0, pick the first set bit searching upward from (last_idx+1) mod PORT_NUM, wrapping
//   - register it as grant_idx and go to XFER; grant becomes visible 1 cycle after req seen
//   - if req==0, stay in IDLE
//  XFER:
//   - fifo_rd[grant_idx] = fifo_nempty[grant_idx] & out_ready; combinational from registered grant
//   - all other fifo_rd bits are 0
//   - a read with fifo_eop[grant_idx]=1 completes the packet. Next cycle:
//     - state=IDLE, last_idx=grant_idx, pkt_cnt+1
//     - one dead cycle always follows before the next grant
//   - port_en[grant_idx] dropping mid-packet does not release the grant; the packet finishes
//   - granted FIFO empty or out_ready=0: stall in XFER, no read, grant held
//   - fifo_eop high while no read occurs: ignored
//  fifo_sel_code = busy ? {1'b1, grant_idx[6:0]} : 8'd0 (registered, same timing as busy).
//  Only one fifo_rd bit may ever be high; a packet from one port is never interleaved with another.
//  Fairness: a port with continuous requests waits at most PORT_NUM-1 packets.
// CONFIGURATION
//  FIFO_SCHED_TIMEOUT_EN defined:
//   - stall counter (16 bit) clears on entry to XFER and on every read; increments each XFER cycle with no read
//   - when the counter reaches TIMEOUT_CYC:
//     - sched_timeout pulses 1 cycle
//     - state goes to IDLE with last_idx=grant_idx
//     - pkt_cnt is not incremented
//   - a read in the same cycle as the limit wins; no abort occurs
//  FIFO_SCHED_TIMEOUT_EN undefined:
//   - no counter logic; sched_timeout tied 0
//   - a stalled grant is held indefinitely
// TESTING
//  1. Reset:
//     - glb_rst=1 for 3 cycles with fifo_nempty=6'h3F -> fifo_rd=0, fifo_sel_code=0, busy=0, pkt_cnt=0
//     - after release, first grant goes to port 0 (code 8'd128)
//  2. Round-robin:
//     - all 6 ports hold 1-word packets (eop=1), out_ready=1, port_en=6'h3F
//     - grants 0,1,2,3,4,5,0 with codes 128..133,128
//     - IDLE gap each packet; pkt_cnt=6 after six
//  3. Packet hold:
//     - port 2 sends a 4-word packet with out_ready low on word 2, port 3 requests throughout
//     - fifo_rd[2] pulses 4 times, never fifo_rd[3] until port 2 eop read
//     - port 3 granted next
//  4. Mask:
//     - port_en=6'b000101 with all FIFOs non-empty -> only ports 0,2 alternate
//     - clearing port_en[2] mid-packet -> port 2 packet still completes
//  5. Reset mid-packet:
//     - glb_rst asserted during port 4 word 2 -> busy=0 next edge, pkt_cnt unchanged (0)
//     - port 0 granted first after release
//  6. Timeout:
//     - with FIFO_SCHED_TIMEOUT_EN and TIMEOUT_CYC=8, port 1 empties mid-packet
//     - sched_timeout pulses after 8 stall cycles; port 2 granted next; pkt_cnt unchanged
//     - without the macro, grant stays on port 1

Source files
------------

// File: rtl/fifo_rr_scheduler.sv
// ----------------------------------------------------------------------------
// fifo_rr_scheduler
//
// Packet-level round-robin scheduler that shares one downstream read path
// among PORT_NUM input FIFOs. A non-empty, enabled FIFO is granted and keeps
// the grant until its end-of-packet word has been read. Packets from
// different FIFOs are never interleaved.
//
// Optional feature macro: FIFO_SCHED_TIMEOUT_EN
//   When defined, a grant that stalls for TIMEOUT_CYC consecutive cycles
//   without a read is aborted. sched_timeout pulses for one cycle and the
//   completed-packet counter is left unchanged.
//   When undefined, a stalled grant is held indefinitely and sched_timeout
//   is tied to 0.
//
// Parameters
//   PORT_NUM     number of input FIFOs (2..127)
//   CNT_W        width of the completed-packet counter
//   TIMEOUT_CYC  stall cycles before abort (1..65535), timeout build only
//
// Ports
//   glb_clk        in   single clock, rising edge
//   glb_rst        in   synchronous reset, active-high
//   port_en        in   per-FIFO arbitration enable
//   fifo_nempty    in   FIFO i holds at least one word
//   fifo_eop       in   head word of FIFO i ends its packet
//   out_ready      in   downstream accepts a word this cycle
//   fifo_rd        out  one-hot read strobe to the granted FIFO
//   fifo_sel_code  out  8'd128 + grant index while granted, 8'd0 otherwise
//   busy           out  grant held
//   pkt_cnt        out  completed packets, wraps modulo 2^CNT_W
//   sched_timeout  out  one-cycle pulse when a stalled grant is aborted
// ----------------------------------------------------------------------------
module fifo_rr_scheduler #(
    parameter int PORT_NUM    = 6,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                glb_clk,
    input  logic                glb_rst,
    input  logic [PORT_NUM-1:0] port_en,
    input  logic [PORT_NUM-1:0] fifo_nempty,
    input  logic [PORT_NUM-1:0] fifo_eop,
    input  logic                out_ready,
    output logic [PORT_NUM-1:0] fifo_rd,
    output logic [7:0]          fifo_sel_code,
    output logic                busy,
    output logic [CNT_W-1:0]    pkt_cnt,
    output logic                sched_timeout
);

    localparam int IDX_W = $clog2(PORT_NUM);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Elaboration-time guard on the legal parameter ranges.
    if (PORT_NUM < 2 || PORT_NUM > 127 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_param
        $error("fifo_rr_scheduler: parameter out of range");
    end

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   last_idx;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;
    logic               pick_found;
    logic [PORT_NUM-1:0] req;
    logic               rd_fire;
    logic               eop_done;
    logic               abort_now;

    assign req = port_en & fifo_nempty;

    // The grant is registered, so the read strobe only depends on the
    // granted FIFO's own status and downstream readiness. port_en is
    // deliberately ignored here so a started packet always finishes.
    assign rd_fire  = (state_q == XFER) && fifo_nempty[grant_idx] && out_ready;
    assign eop_done = rd_fire && fifo_eop[grant_idx];

    assign busy          = (state_q == XFER);
    assign fifo_sel_code = busy ? (8'd128 | 8'(grant_idx)) : 8'd0;

    // Round-robin pick: scan upward starting one past the last served port,
    // wrapping at PORT_NUM, and keep the first requester found.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int k = 1; k <= PORT_NUM; k++) begin
            if (int'(last_idx) + k >= PORT_NUM) begin
                cand = IDX_W'(int'(last_idx) + k - PORT_NUM);
            end else begin
                cand = IDX_W'(int'(last_idx) + k);
            end
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // One-hot read strobe towards the granted FIFO.
    always_comb begin
        fifo_rd = '0;
        if (rd_fire) begin
            fifo_rd[grant_idx] = 1'b1;
        end
    end

    // Next-state logic. Leaving XFER always passes through IDLE, which gives
    // the mandatory dead cycle between packets.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (eop_done || abort_now) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, grant, round-robin pointer and packet counter.
    always_ff @(posedge glb_clk) begin
        if (glb_rst) begin
            state_q   <= IDLE;
            grant_idx <= '0;
            last_idx  <= IDX_W'(PORT_NUM - 1);
            pkt_cnt   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && (|req)) begin
                grant_idx <= pick_idx;
            end
            if (eop_done || abort_now) begin
                last_idx <= grant_idx;
            end
            if (eop_done) begin
                pkt_cnt <= pkt_cnt + CNT_W'(1);
            end
        end
    end

`ifdef FIFO_SCHED_TIMEOUT_EN
    logic [15:0] stall_cnt;
    logic        sched_timeout_q;

    // Abort on the stall cycle that brings the count up to TIMEOUT_CYC;
    // a read in that cycle means it is not a stall, so the read wins.
    assign abort_now = (state_q == XFER) && !rd_fire &&
                       ((stall_cnt + 16'd1) == 16'(TIMEOUT_CYC));

    // Stall counter is held at zero while idle so every grant starts fresh,
    // and restarts on each successful read.
    always_ff @(posedge glb_clk) begin
        if (glb_rst) begin
            stall_cnt       <= '0;
            sched_timeout_q <= 1'b0;
        end else begin
            sched_timeout_q <= abort_now;
            if (state_q == IDLE || rd_fire || abort_now) begin
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    assign sched_timeout = sched_timeout_q;
`else
    assign abort_now     = 1'b0;
    assign sched_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// ----------------------------------------------------------------------------
// tb_fifo_rr_scheduler
//
// Directed bench for fifo_rr_scheduler with PORT_NUM=6 and TIMEOUT_CYC=8.
// FIFO status is driven directly as nempty/eop vectors per step; every
// expected value below is worked out by hand from the scheduling rules.
// Honours FIFO_SCHED_TIMEOUT_EN for the stall scenario.
// ----------------------------------------------------------------------------
module tb_fifo_rr_scheduler;

    localparam int PORT_NUM    = 6;
    localparam int CNT_W       = 16;
    localparam int TIMEOUT_CYC = 8;

    logic                glb_clk = 1'b0;
    logic                glb_rst;
    logic [PORT_NUM-1:0] port_en;
    logic [PORT_NUM-1:0] fifo_nempty;
    logic [PORT_NUM-1:0] fifo_eop;
    logic                out_ready;
    logic [PORT_NUM-1:0] fifo_rd;
    logic [7:0]          fifo_sel_code;
    logic                busy;
    logic [CNT_W-1:0]    pkt_cnt;
    logic                sched_timeout;

    int checks = 0;
    int errors = 0;

    always #5 glb_clk = ~glb_clk;

    fifo_rr_scheduler #(
        .PORT_NUM    (PORT_NUM),
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .glb_clk       (glb_clk),
        .glb_rst       (glb_rst),
        .port_en       (port_en),
        .fifo_nempty   (fifo_nempty),
        .fifo_eop      (fifo_eop),
        .out_ready     (out_ready),
        .fifo_rd       (fifo_rd),
        .fifo_sel_code (fifo_sel_code),
        .busy          (busy),
        .pkt_cnt       (pkt_cnt),
        .sched_timeout (sched_timeout)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge glb_clk);
        #1;
    endtask

    // Drive FIFO status, then let combinational outputs settle.
    task automatic applyStimulus(input logic [PORT_NUM-1:0] en,
                                 input logic [PORT_NUM-1:0] nempty,
                                 input logic [PORT_NUM-1:0] eop,
                                 input logic                ready);
        port_en     = en;
        fifo_nempty = nempty;
        fifo_eop    = eop;
        out_ready   = ready;
        #1;
    endtask

    task automatic checkOutput(input string tag,
                               input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        // Reset held for three edges with every FIFO non-empty.
        glb_rst = 1'b1;
        applyStimulus(6'h3F, 6'h3F, 6'h00, 1'b1);
        repeat (3) tick();
        checkOutput("rst_rd",      32'(fifo_rd),       0);
        checkOutput("rst_code",    32'(fifo_sel_code), 0);
        checkOutput("rst_busy",    32'(busy),          0);
        checkOutput("rst_cnt",     32'(pkt_cnt),       0);
        checkOutput("rst_timeout", 32'(sched_timeout), 0);

        // Round-robin over single-word packets: 0,1,2,3,4,5,0 with a dead
        // cycle after each packet.
        glb_rst = 1'b0;
        applyStimulus(6'h3F, 6'h3F, 6'h3F, 1'b1);
        for (int i = 0; i < 7; i++) begin
            tick();
            checkOutput("rr_code", 32'(fifo_sel_code), 128 + (i % 6));
            checkOutput("rr_rd",   32'(fifo_rd),       1 << (i % 6));
            tick();
            checkOutput("rr_idle_busy", 32'(busy),    0);
            checkOutput("rr_idle_rd",   32'(fifo_rd), 0);
            checkOutput("rr_cnt",       32'(pkt_cnt), i + 1);
        end

        // Packet hold: last served is 0, ports 2 and 3 request. Port 2 sends
        // four words with one stall; eop during the stall must be ignored.
        applyStimulus(6'h3F, 6'b001100, 6'h00, 1'b1);
        tick();
        checkOutput("hold_code_w1", 32'(fifo_sel_code), 130);
        checkOutput("hold_rd_w1",   32'(fifo_rd),       6'b000100);
        tick();
        applyStimulus(6'h3F, 6'b001100, 6'b000100, 1'b0);
        checkOutput("hold_stall_rd",   32'(fifo_rd), 0);
        checkOutput("hold_stall_busy", 32'(busy),    1);
        tick();
        applyStimulus(6'h3F, 6'b001100, 6'h00, 1'b1);
        checkOutput("hold_code_w2", 32'(fifo_sel_code), 130);
        checkOutput("hold_rd_w2",   32'(fifo_rd),       6'b000100);
        tick();
        checkOutput("hold_rd_w3",   32'(fifo_rd),       6'b000100);
        tick();
        applyStimulus(6'h3F, 6'b001100, 6'b000100, 1'b1);
        checkOutput("hold_rd_w4",   32'(fifo_rd),       6'b000100);
        tick();
        checkOutput("hold_done_busy", 32'(busy),    0);
        checkOutput("hold_done_cnt",  32'(pkt_cnt), 8);
        applyStimulus(6'h3F, 6'b001100, 6'b001000, 1'b1);
        tick();
        checkOutput("hold_next_code", 32'(fifo_sel_code), 131);
        checkOutput("hold_next_rd",   32'(fifo_rd),       6'b001000);
        tick();
        checkOutput("hold_next_cnt",  32'(pkt_cnt), 9);

        // Mask: only ports 0 and 2 enabled, last served is 3.
        applyStimulus(6'b000101, 6'h3F, 6'h3F, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("mask_code", 32'(fifo_sel_code), (i % 2 == 0) ? 128 : 130);
            checkOutput("mask_rd",   32'(fifo_rd),       (i % 2 == 0) ? 1 : 4);
            tick();
            checkOutput("mask_cnt",  32'(pkt_cnt), 10 + i);
        end
        // Port 2 granted next; its enable drops mid-packet.
        applyStimulus(6'b000101, 6'h3F, 6'h00, 1'b1);
        tick();
        checkOutput("mask_drop_code_w1", 32'(fifo_sel_code), 130);
        applyStimulus(6'b000001, 6'h3F, 6'h00, 1'b1);
        checkOutput("mask_drop_rd_w1",   32'(fifo_rd), 6'b000100);
        tick();
        checkOutput("mask_drop_code_w2", 32'(fifo_sel_code), 130);
        applyStimulus(6'b000001, 6'h3F, 6'b000100, 1'b1);
        checkOutput("mask_drop_rd_w2",   32'(fifo_rd), 6'b000100);
        tick();
        checkOutput("mask_drop_busy", 32'(busy),    0);
        checkOutput("mask_drop_cnt",  32'(pkt_cnt), 13);

        // Reset in the middle of a port 4 packet.
        applyStimulus(6'h3F, 6'b010000, 6'h00, 1'b1);
        tick();
        checkOutput("mid_rst_code", 32'(fifo_sel_code), 132);
        checkOutput("mid_rst_rd",   32'(fifo_rd),       6'b010000);
        tick();
        checkOutput("mid_rst_busy_w2", 32'(busy), 1);
        glb_rst = 1'b1;
        applyStimulus(6'h3F, 6'b010000, 6'h00, 1'b1);
        tick();
        checkOutput("mid_rst_busy_after", 32'(busy),          0);
        checkOutput("mid_rst_cnt_after",  32'(pkt_cnt),       0);
        checkOutput("mid_rst_code_after", 32'(fifo_sel_code), 0);
        checkOutput("mid_rst_rd_after",   32'(fifo_rd),       0);
        glb_rst = 1'b0;
        applyStimulus(6'h3F, 6'h3F, 6'h3F, 1'b1);
        tick();
        checkOutput("post_rst_code", 32'(fifo_sel_code), 128);
        checkOutput("post_rst_rd",   32'(fifo_rd),       6'b000001);
        tick();
        checkOutput("post_rst_cnt",  32'(pkt_cnt), 1);

        // Stall: port 1 granted, one word read, then it runs empty while
        // port 2 keeps requesting.
        applyStimulus(6'h3F, 6'b000110, 6'h00, 1'b1);
        tick();
        checkOutput("stall_code", 32'(fifo_sel_code), 129);
        checkOutput("stall_rd_w1", 32'(fifo_rd),      6'b000010);
        tick();
        applyStimulus(6'h3F, 6'b000100, 6'h00, 1'b1);
        checkOutput("stall_rd_empty", 32'(fifo_rd), 0);
        for (int k = 1; k < TIMEOUT_CYC; k++) begin
            tick();
            checkOutput("stall_busy",    32'(busy),          1);
            checkOutput("stall_timeout", 32'(sched_timeout), 0);
        end
        tick();
`ifdef FIFO_SCHED_TIMEOUT_EN
        checkOutput("to_busy",  32'(busy),          0);
        checkOutput("to_pulse", 32'(sched_timeout), 1);
        checkOutput("to_cnt",   32'(pkt_cnt),       1);
        tick();
        checkOutput("to_next_code",  32'(fifo_sel_code), 130);
        checkOutput("to_pulse_end",  32'(sched_timeout), 0);
        checkOutput("to_next_cnt",   32'(pkt_cnt),       1);
`else
        checkOutput("hold_stalled_busy",    32'(busy),          1);
        checkOutput("hold_stalled_code",    32'(fifo_sel_code), 129);
        checkOutput("hold_stalled_timeout", 32'(sched_timeout), 0);
        repeat (20) tick();
        checkOutput("hold_stalled_code_late", 32'(fifo_sel_code), 129);
        applyStimulus(6'h3F, 6'b000110, 6'b000010, 1'b1);
        checkOutput("hold_stalled_rd_eop", 32'(fifo_rd), 6'b000010);
        tick();
        checkOutput("hold_stalled_cnt", 32'(pkt_cnt), 2);
        tick();
        checkOutput("hold_stalled_next_code", 32'(fifo_sel_code), 130);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
